// File: rtl/vga_pkg.sv
// Shared video definitions: active area, coordinate/colour types and the
// rectangle-writer FSM state encoding.
package vga_pkg;
   localparam int COORD_W  = 10;
   localparam int RGB_W    = 12;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb_t;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} wr_state_e;

   localparam coord_t X_MAX = coord_t'(H_ACTIVE - 1);
   localparam coord_t Y_MAX = coord_t'(V_ACTIVE - 1);

   function automatic coord_t clip(input coord_t v, input coord_t lim);
      return (v > lim) ? lim : v;
   endfunction
endpackage

// File: rtl/vga_xy_stepper.sv
// Row-major x/y walker over an inclusive rectangle; load sets bounds and
// origin, step advances one pixel, last flags the bottom-right corner.
module vga_xy_stepper
   import vga_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   step,
   input  coord_t ld_x0,
   input  coord_t ld_y0,
   input  coord_t ld_x1,
   input  coord_t ld_y1,
   output coord_t x,
   output coord_t y,
   output logic   last
);
   coord_t x0_q, x1_q, y1_q;

   assign last = (x == x1_q) && (y == y1_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
         x    <= '0;
         y    <= '0;
      end else if (load) begin
         x0_q <= ld_x0;
         x1_q <= ld_x1;
         y1_q <= ld_y1;
         x    <= ld_x0;
         y    <= ld_y0;
      end else if (step && !last) begin
         // holding at the final corner keeps the counters inside the clipped bounds
         if (x == x1_q) begin
            x <= x0_q;
            y <= y + coord_t'(1);
         end else begin
            x <= x + coord_t'(1);
         end
      end
   end
endmodule

// File: rtl/vga_rect_writer.sv
// Rectangle-fill drawing engine feeding the frame memory write port.
// Build option VBLANK_ONLY_EN: pixel writes are issued only while vblank is high.
module vga_rect_writer
   import vga_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   cmd_valid,
   output logic   cmd_ready,
   input  coord_t cmd_x0,
   input  coord_t cmd_y0,
   input  coord_t cmd_x1,
   input  coord_t cmd_y1,
   input  rgb_t   cmd_rgb,
   input  logic   vblank,
   output logic   wr_valid,
   input  logic   wr_ready,
   output coord_t wr_x,
   output coord_t wr_y,
   output rgb_t   wr_rgb,
   output logic   busy,
   output logic   done
);
   wr_state_e state;
   logic      fill_q;
   rgb_t      rgb_q;
   logic      last;
   coord_t    x0c, y0c, x1c, y1c;
   logic      accept, empty, xfer;

   assign x0c = clip(cmd_x0, X_MAX);
   assign y0c = clip(cmd_y0, Y_MAX);
   assign x1c = clip(cmd_x1, X_MAX);
   assign y1c = clip(cmd_y1, Y_MAX);
   assign empty = (x0c > x1c) || (y0c > y1c);

   // gated by rst so the handshake stays closed while reset is held
   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE);
   assign wr_rgb    = rgb_q;

`ifdef VBLANK_ONLY_EN
   assign wr_valid = fill_q && vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign wr_valid = fill_q;
`endif

   assign xfer = wr_valid && wr_ready;

   vga_xy_stepper u_step (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .step  (xfer),
      .ld_x0 (x0c),
      .ld_y0 (y0c),
      .ld_x1 (x1c),
      .ld_y1 (y1c),
      .x     (wr_x),
      .y     (wr_y),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         fill_q <= 1'b0;
         done   <= 1'b0;
         rgb_q  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               rgb_q <= cmd_rgb;
               if (empty) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state  <= S_FILL;
                  fill_q <= 1'b1;
               end
            end
            S_FILL: if (xfer && last) begin
               state  <= S_DONE;
               fill_q <= 1'b0;
               done   <= 1'b1;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_rect_writer.sv
// Randomized bench for vga_rect_writer against a queue-based pixel list model.
module tb_vga_rect_writer;
   import vga_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   cmd_valid = 1'b0;
   logic   cmd_ready;
   coord_t cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   rgb_t   cmd_rgb = '0;
   logic   vblank = 1'b0;
   logic   wr_valid;
   logic   wr_ready = 1'b0;
   coord_t wr_x, wr_y;
   rgb_t   wr_rgb;
   logic   busy, done;

   int num_cmp = 0;
   int num_err = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   vga_rect_writer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
      .cmd_rgb(cmd_rgb), .vblank(vblank), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_cmp++;
      if (got !== exp) begin
         num_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // expected pixel list from the clipped inclusive rectangle, row-major
   task automatic build_model(input int x0, y0, x1, y1, input int rgb);
      int xa, ya, xb, yb;
      exp_q.delete();
      xa = (x0 > H_ACTIVE-1) ? H_ACTIVE-1 : x0;
      xb = (x1 > H_ACTIVE-1) ? H_ACTIVE-1 : x1;
      ya = (y0 > V_ACTIVE-1) ? V_ACTIVE-1 : y0;
      yb = (y1 > V_ACTIVE-1) ? V_ACTIVE-1 : y1;
      for (int yy = ya; yy <= yb; yy++)
         for (int xx = xa; xx <= xb; xx++)
            exp_q.push_back({yy[9:0], xx[9:0], rgb[11:0]});
   endtask

   // rdy_mode: 0 always ready, 1 toggle 1,0,..., 2 random
   // vb_mode: 0 random vblank, 1 vblank low for 10 cycles then high
   task automatic run_cmd(input int x0, y0, x1, y1, input int rgb,
                          input int rdy_mode, input int vb_mode, input int rst_after);
      int          n_exp, nwr, last_c;
      logic        acc, seen_done, hold_v, do_rst;
      logic [31:0] snap, got, exp;
      build_model(x0, y0, x1, y1, rgb);
      n_exp = exp_q.size();
      @(posedge clk); #1;
      cmd_x0 = coord_t'(x0); cmd_y0 = coord_t'(y0);
      cmd_x1 = coord_t'(x1); cmd_y1 = coord_t'(y1);
      cmd_rgb = rgb_t'(rgb); cmd_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk); acc = cmd_ready;
         @(posedge clk); #1;
      end
      chk("accept", {31'd0, acc}, 32'd1);
      cmd_valid = 1'b0;
      cmd_x0 = coord_t'($urandom); cmd_y0 = coord_t'($urandom);
      cmd_x1 = coord_t'($urandom); cmd_y1 = coord_t'($urandom);
      cmd_rgb = rgb_t'($urandom);
      nwr = 0; last_c = -1; seen_done = 1'b0; hold_v = 1'b0; do_rst = 1'b0; snap = '0;
      for (int c = 0; c < 4000 && !seen_done; c++) begin
         case (rdy_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = (c % 2 == 0);
            default: wr_ready = 1'($urandom_range(0, 1));
         endcase
         vblank = (vb_mode == 1) ? (c >= 10) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (hold_v) chk("stall_hold", {wr_y, wr_x, wr_rgb}, snap);
         hold_v = 1'b0;
`ifdef VBLANK_ONLY_EN
         if (busy && !vblank) chk("vb_gate", {31'd0, wr_valid}, 32'd0);
`endif
         if (done) begin
            seen_done = 1'b1;
            chk("done_vld", {31'd0, wr_valid}, 32'd0);
            chk("n_writes", nwr, n_exp);
            if (n_exp > 0) chk("done_lat", c - last_c, 32'd1);
            else           chk("empty_lat", c, 32'd0);
         end else if (wr_valid && wr_ready) begin
            got = {wr_y, wr_x, wr_rgb};
            if (exp_q.size() == 0) chk("extra_wr", got, 32'hFFFF_FFFF);
            else begin
               exp = exp_q.pop_front();
               chk("pixel", got, exp);
            end
            nwr++; last_c = c;
            if (rst_after > 0 && nwr == rst_after) do_rst = 1'b1;
         end else if (busy) begin
            snap = {wr_y, wr_x, wr_rgb}; hold_v = 1'b1;
         end
         @(posedge clk); #1;
         if (do_rst) begin
            rst = 1'b1; #1;
            chk("rst_vld", {31'd0, wr_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rdy", {31'd0, cmd_ready}, 32'd0);
            chk("rst_x", wr_x, 32'd0);
            repeat (2) begin @(negedge clk); chk("rst_done", {31'd0, done}, 32'd0); end
            rst = 1'b0; #1;
            chk("rel_rdy", {31'd0, cmd_ready}, 32'd1);
            repeat (3) begin
               @(negedge clk);
               chk("post_done", {31'd0, done}, 32'd0);
               chk("post_busy", {31'd0, busy}, 32'd0);
            end
            return;
         end
      end
      if (!seen_done) chk("timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("idle_rdy", {31'd0, cmd_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int x0, y0;
      #1;
      chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_wvld", {31'd0, wr_valid}, 32'd0);
      chk("rst_wxy", {wr_y, wr_x, wr_rgb}, 32'd0);
      chk("rst_bd", {30'd0, busy, done}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      chk("rel_ready", {31'd0, cmd_ready}, 32'd1);

      run_cmd(2, 3, 4, 4, 12'hF00, 0, 0, 0);
      run_cmd(2, 3, 4, 4, 12'hF00, 1, 0, 0);
      run_cmd(5, 0, 4, 0, 12'h0F0, 0, 0, 0);
      run_cmd(630, 470, 1000, 900, 12'h00F, 0, 0, 0);
      run_cmd(2, 3, 4, 4, 12'hF00, 0, 0, 3);
      run_cmd(2, 3, 4, 4, 12'hF00, 0, 1, 0);
      run_cmd(0, 0, 0, 0, 12'hABC, 2, 0, 0);
      run_cmd(639, 479, 1023, 1023, 12'h123, 2, 0, 0);
      for (int i = 0; i < 30; i++) begin
         x0 = (i % 3 == 0) ? int'($urandom_range(620, 1023)) : int'($urandom_range(0, 1023));
         y0 = (i % 3 == 0) ? int'($urandom_range(460, 1023)) : int'($urandom_range(0, 1023));
         run_cmd(x0, y0, (x0 + int'($urandom_range(0, 12))) & 1023,
                 (y0 + int'($urandom_range(0, 12))) & 1023,
                 int'($urandom_range(0, 4095)), 2, 0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
      $finish;
   end
endmodule
